// File: rtl/cic_cfg_ctrl.sv
// Run-time configuration sequencer for the CIC decimator: validates factor/bypass
// requests, flushes the CIC, applies the new settings and masks the start-up transient.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal operation, requests accepted, outputs pass through
// ST_FLUSH  | CIC held in reset for FLUSH_CYCLES clocks, samples dropped
// ST_SETTLE | CIC running, first Q*N CIC outputs masked
module cic_cfg_ctrl #(
  parameter int DEC_WIDTH    = 4,
  parameter int Q            = 1,
  parameter int N            = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int DEF_DEC      = 1,
  parameter bit DEF_BYPASS   = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [DEC_WIDTH:0] cfg_dec_factor_i,
  input  logic               cfg_bypass_i,
  output logic               cfg_err_o,
  input  logic               in_valid_i,
  output logic               in_drop_o,
  output logic               cic_valid_in_o,
  output logic [DEC_WIDTH:0] cic_dec_factor_o,
  output logic               cic_bypass_o,
  output logic               cic_rst_n_o,
  input  logic               cic_valid_out_i,
  input  logic               cic_overflow_i,
  input  logic               cic_underflow_i,
  output logic               out_valid_o,
  output logic               busy_o,
  output logic               ovf_sticky_o,
  output logic               unf_sticky_o,
  input  logic               sat_clr_i
);

  localparam int DW         = DEC_WIDTH + 1;
  localparam int SETTLE_LEN = Q * N;
  localparam int FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SCW        = (SETTLE_LEN > 0) ? $clog2(SETTLE_LEN + 1) : 1;

  localparam logic [FCW-1:0] FLUSH_LOAD  = FCW'(FLUSH_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_LEN);
  localparam logic [DW-1:0]  DEF_DEC_V   = DW'(DEF_DEC);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [SCW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [DW-1:0]   dec_q, dec_d;
  logic            byp_q, byp_d;
  logic            flush_q, flush_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            accept;
  logic            legal;
  logic            acc_ok;
  logic            acc_bad;

  // Legal factors are exactly the powers of two representable in DW bits.
  assign legal   = $onehot(cfg_dec_factor_i);
  assign accept  = cfg_valid_i & (state_q == ST_RUN);
  assign acc_ok  = accept & legal;
  assign acc_bad = accept & ~legal;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_RUN;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      dec_q        <= DEF_DEC_V;
      byp_q        <= DEF_BYPASS;
      flush_q      <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      dec_q        <= dec_d;
      byp_q        <= byp_d;
      flush_q      <= flush_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    dec_d        = dec_q;
    byp_d        = byp_q;
    unique case (state_q)
      ST_RUN: begin
        if (acc_ok) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
          dec_d       = cfg_dec_factor_i;
          byp_d       = cfg_bypass_i;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          // Bypass has no filter transient, so there is nothing to settle.
          if (byp_q || (SETTLE_LEN == 0)) begin
            state_d = ST_RUN;
          end else begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SETTLE_LOAD;
          end
        end else begin
          flush_cnt_d = flush_cnt_q - FCW'(1);
        end
      end
      ST_SETTLE: begin
        if (cic_valid_out_i) begin
          settle_cnt_d = settle_cnt_q - SCW'(1);
          if (settle_cnt_q <= SCW'(1)) begin
            state_d      = ST_RUN;
            settle_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cfg_ready_o    = 1'b0;
    cic_valid_in_o = 1'b0;
    in_drop_o      = 1'b0;
    out_valid_o    = 1'b0;
    busy_o         = 1'b1;
    unique case (state_q)
      ST_RUN: begin
        cfg_ready_o    = 1'b1;
        cic_valid_in_o = in_valid_i;
        out_valid_o    = cic_valid_out_i;
        busy_o         = 1'b0;
      end
      ST_FLUSH: begin
        in_drop_o = in_valid_i;
      end
      ST_SETTLE: begin
        cic_valid_in_o = in_valid_i;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // A same-cycle set beats both sat_clr and the clear on a legal accept.
  always_comb begin
    flush_d = (state_d == ST_FLUSH);
    err_d   = acc_bad;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (sat_clr_i || acc_ok) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (out_valid_o && cic_overflow_i) begin
      ovf_d = 1'b1;
    end
    if (out_valid_o && cic_underflow_i) begin
      unf_d = 1'b1;
    end
  end

  assign cic_rst_n_o      = rst_n_i & ~flush_q;
  assign cic_dec_factor_o = dec_q;
  assign cic_bypass_o     = byp_q;
  assign cfg_err_o        = err_q;
  assign ovf_sticky_o     = ovf_q;
  assign unf_sticky_o     = unf_q;

endmodule
